// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder, one bit per clock, LSB first, valid/ready on both sides.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             c_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             fa_s;
    logic             fa_co;

    // Subtraction is A + ~B + 1, so only the B load value and initial carry change.
    always_comb begin
        b_load     = B;
        carry_load = Cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (Sub) begin
            b_load     = ~B;
            carry_load = 1'b1;
        end
`endif
    end

    full_adder u_fa (
        .a  (a_reg[0]),
        .b  (b_reg[0]),
        .ci (carry_reg),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            s_reg         <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            c_reg         <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= A;
                        b_reg        <= b_load;
                        carry_reg    <= carry_load;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so the first (LSB) result lands at bit 0 after WIDTH steps.
                    s_reg     <= {fa_s, s_reg[WIDTH-1:1]};
                    carry_reg <= fa_co;
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    if (cnt_reg == LAST) begin
                        c_reg         <= fa_co;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign S         = s_reg;
    assign C         = c_reg;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8; subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         C;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C         (C)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [W:0]  exp_q[$];
    int          hs_q[$];
    logic [W:0]  mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: handshake log and result scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready && !rst) hs_q.push_back(cyc);
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("txn cyc=%0d S=%02h C=%0b expect S=%02h C=%0b", cyc, S, C, mon_e[W-1:0], mon_e[W]);
                chk("sb_S", {24'd0, S}, {24'd0, mon_e[W-1:0]});
                chk("sb_C", {31'd0, C}, {31'd0, mon_e[W]});
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sb, input logic [W-1:0] es, input logic ec);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
        A = a; B = b; Cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sb;
`else
        if (sb) chk("sub_vector_without_sub", 32'd1, 32'd0);
`endif
        in_valid = 1'b1;
        exp_q.push_back({ec, es});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 50);
        if (lat >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    logic [W-1:0] va[3] = '{8'h0F, 8'hAA, 8'h7F};
    logic [W-1:0] vb[3] = '{8'h01, 8'h55, 8'h7F};
    logic         vc[3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] vs[3] = '{8'h10, 8'h00, 8'hFE};
    logic         vco[3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int lat;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_S", {24'd0, S}, 32'd0);
        chk("rst_C", {31'd0, C}, 32'd0);

        // Latency and single-cycle out_valid
        @(posedge clk); #1;
        send(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
        wait_out(lat);
        chk("latency", lat, 32'd9);
        @(negedge clk);
        chk("out_valid_one_cycle", {31'd0, out_valid}, 32'd0);

        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        send(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1);
        send(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0);
        wait_out(lat);

        // Back-pressure in DONE with in_valid pulses that must be ignored
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'hC3, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 1); A = 8'h11; B = 8'h22;
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_S", {24'd0, S}, 32'hFF);
            chk("hold_C", {31'd0, C}, 32'd0);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        chk("no_capture_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-RUN with counter=3
        @(posedge clk); #1;
        send(8'hAA, 8'hAA, 1'b0, 1'b0, 8'h54, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_S", {24'd0, S}, 32'd0);
        chk("midrst_C", {31'd0, C}, 32'd0);
        @(posedge clk); #1;
        send(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
        wait_out(lat);

`ifdef SERIAL_ADDER_SUB_EN
        send(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        send(8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
        send(8'h10, 8'h01, 1'b0, 1'b0, 8'h11, 1'b0);
        wait_out(lat);
`endif

        // Back-to-back with in_valid held high
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        hs_q.delete();
        for (int k = 0; k < 3; k++) begin
            A = va[k]; B = vb[k]; Cin = vc[k];
            in_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 50);
            if (n >= 50) chk("b2b_timeout", 32'd0, 32'd1);
            exp_q.push_back({vco[k], vs[k]});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("b2b_handshakes", hs_q.size(), 32'd3);
        if (hs_q.size() == 3) begin
            chk("b2b_spacing_0", hs_q[1] - hs_q[0], 32'd10);
            chk("b2b_spacing_1", hs_q[2] - hs_q[1], 32'd10);
        end
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; legal range WIDTH >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set A/B/Cin valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 A  input  WIDTH  addend A, sampled on input handshake.
REQ-007 B  input  WIDTH  addend B, sampled on input handshake.
REQ-008 Cin  input  1  carry-in, sampled on input handshake.
REQ-009 out_valid  output  1  S/C hold a completed result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 S  output  WIDTH  sum, meaningful only while out_valid=1.
REQ-012 C  output  1  final carry-out, meaningful only while out_valid=1.
REQ-013 Sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN (see Configuration).

Function
REQ-014 Datapath SHALL instantiate exactly one FullAdder and process one bit per clock, LSB first.
REQ-015 FSM states: IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid&in_ready, latch A and B into shift registers, carry register <= Cin, bit counter <= 0, go to RUN; otherwise stay.
REQ-017 RUN: each cycle, feed shift-register LSBs and carry register to FullAdder; shift sum bit into S from the MSB side; carry register <= FullAdder C; shift operands right; counter++.
REQ-018 RUN: when counter == WIDTH-1, perform the last bit step and go to DONE; C <= final carry.
REQ-019 Latency: out_valid first high WIDTH+1 cycles after the input-handshake cycle.
REQ-020 DONE: S and C SHALL hold stable until out_valid&out_ready, then go to IDLE; out_valid low in the following cycle.
REQ-021 in_valid outside IDLE SHALL be ignored (no capture, no queueing); back-to-back minimum spacing is WIDTH+2 cycles.
REQ-022 Arithmetic: {C,S} = A + B + Cin, modulo 2^(WIDTH+1); no overflow flag.
REQ-023 Bit counter width SHALL be clog2(WIDTH), with no wrap-around before the RUN exit.

Reset
REQ-024 rst=1 at a clock edge, in any state, SHALL force IDLE, discard any in-flight operation, and clear the counter, carry register, and shift registers.
REQ-025 Output reset values: in_ready=1 (the cycle after reset), out_valid=0, S=0, C=0.
REQ-026 rst takes priority over a simultaneous input or output handshake.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN defined: Sub port exists and is sampled on the input handshake.
- If Sub=1: B is inverted bitwise when latched, the carry register initialises to 1, and Cin is ignored, so S = A - B mod 2^WIDTH and C=1 means no borrow.
- If Sub=0: behaviour is identical to add mode.
REQ-028 Macro undefined: Sub port, inversion logic and carry-init mux are absent; the block is add only.

Verification (WIDTH=8)
REQ-029 A=0x5A, B=0x33, Cin=0, out_ready=1 -> S=0x8D, C=0; out_valid high exactly 9 cycles after the handshake, for 1 cycle.
REQ-030 A=0xFF, B=0x01, Cin=0 -> S=0x00, C=1; A=0xFF, B=0xFF, Cin=1 -> S=0xFF, C=1.
REQ-031 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid, S and C stable, in_ready=0, no operand captured; release -> IDLE next cycle.
REQ-032 Assert rst in RUN with counter=3 -> next cycle in_ready=1, out_valid=0, S=0, C=0; then A=0x01, B=0x02 -> S=0x03, C=0.
REQ-033 With SERIAL_ADDER_SUB_EN: Sub=1, A=0x10, B=0x01 -> S=0x0F, C=1; Sub=1, A=0x00, B=0x01 -> S=0xFF, C=0.
REQ-034 Back-to-back: in_valid held high, out_ready=1 -> successive handshakes spaced exactly 10 cycles apart, all results correct.
